// File: rtl/vscale_dmem_responder_pkg.sv
// Shared dmem access-type encodings (RV funct3), state type and the
// address-phase legality check used by the dmem responder.
package vscale_dmem_responder_pkg;

  localparam int MEM_TYPE_WIDTH = 3;
  localparam int MEM_BE_WIDTH   = 4;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LBU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // An access is bad for an unknown size, an unsigned store, a misaligned
  // half/word, or an address outside the RAM window.
  function automatic logic access_bad(input logic                      wen,
                                      input logic [MEM_TYPE_WIDTH-1:0] size,
                                      input logic [1:0]                addr_lo,
                                      input logic                      in_range);
    logic bad;
    case (size)
      MEM_TYPE_LB:  bad = 1'b0;
      MEM_TYPE_LH:  bad = addr_lo[0];
      MEM_TYPE_LW:  bad = (addr_lo != 2'b00);
      MEM_TYPE_LBU: bad = wen;
      MEM_TYPE_LHU: bad = wen | addr_lo[0];
      default:      bad = 1'b1;
    endcase
    return bad | ~in_range;
  endfunction

endpackage

// File: rtl/vscale_dmem_lane_align.sv
// Byte-lane steering: byte enables and store replication for writes,
// extract-and-extend of the addressed byte/half for loads.
module vscale_dmem_lane_align
  import vscale_dmem_responder_pkg::*;
(
  input  logic [MEM_TYPE_WIDTH-1:0] i_size,
  input  logic [1:0]                i_addr_lo,
  input  logic [31:0]               i_wdata,
  input  logic [31:0]               i_rword,
  output logic [MEM_BE_WIDTH-1:0]   o_be,
  output logic [31:0]               o_wdata,
  output logic [31:0]               o_rdata
);

  logic [31:0] w_shift;

  // Addressed byte/half moved down to bit 0.
  assign w_shift = i_rword >> {i_addr_lo, 3'b000};

  // Lane enables, replicated store data and extended load data per size.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (i_size)
      MEM_TYPE_LB, MEM_TYPE_LBU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_size == MEM_TYPE_LB) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                          : {24'h0, w_shift[7:0]};
      end
      MEM_TYPE_LH, MEM_TYPE_LHU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = (i_size == MEM_TYPE_LH) ? {{16{w_shift[15]}}, w_shift[15:0]}
                                          : {16'h0, w_shift[15:0]};
      end
      MEM_TYPE_LW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = '0;
        o_wdata = '0;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Local data RAM on the vscale dmem port: captures an access in the
// address phase, optionally holds the core for WAIT_CYCLES, then commits
// the store or returns the load in the data phase.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [31:0]               dmem_addr,
  input  logic [31:0]               dmem_wdata_delayed,
  output logic [31:0]               dmem_rdata,
  output logic                      dmem_wait,
  output logic                      dmem_badmem_e
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_e r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic                      r_wen;
  logic [MEM_TYPE_WIDTH-1:0] r_size;
  logic [IDX_W-1:0]          r_idx;
  logic [1:0]                r_lo;
  logic                      r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic                    w_capture;
  logic [31:0]             w_offset;
  logic                    w_in_range;
  logic                    w_bad;
  logic                    w_commit;
  logic [MEM_BE_WIDTH-1:0] w_be;
  logic [31:0]             w_wdata_rep;
  logic [31:0]             w_rword;
  logic [31:0]             w_rdata_ext;

  assign w_capture  = dmem_en & ~dmem_wait;
  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare
  // covers both ends of the window.
  assign w_offset   = dmem_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < LIMIT);
  assign w_bad      = access_bad(dmem_wen, dmem_size, w_offset[1:0], w_in_range);
  assign w_commit   = (r_state == ST_RESP) & r_wen & ~r_err & ~reset;
  assign w_rword    = r_mem[r_idx];

  vscale_dmem_lane_align u_lane_align (
    .i_size    (r_size),
    .i_addr_lo (r_lo),
    .i_wdata   (dmem_wdata_delayed),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  // State and wait counter; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pending access registers, loaded on every accepted address phase.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_wen  <= dmem_wen;
      r_size <= dmem_size;
      r_idx  <= w_offset[IDX_W+1:2];
      r_lo   <= w_offset[1:0];
      r_err  <= w_bad;
    end
  end

  // Next state: a capture starts RESP or WAIT; WAIT counts down to RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (w_capture) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
    endcase
  end

  // Outputs: wait only in WAIT; data phase results only in RESP.
  always_comb begin
    dmem_wait     = (r_state == ST_WAIT);
    dmem_badmem_e = (r_state == ST_RESP) & r_err;
    dmem_rdata    = ((r_state == ST_RESP) & ~r_wen & ~r_err) ? w_rdata_ext : 32'h0;
  end

  // Store commit on the edge that ends RESP, per enabled byte lane.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < MEM_BE_WIDTH; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: two instances (no wait states, and three
// wait states at a non-zero base) against a byte-array reference model.
module tb_vscale_dmem_responder;

  localparam int          DEPTH = 64;
  localparam int          NCYC  = 4096;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam int          WT0   = 0;
  localparam int          WT1   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en    [2];
  logic        wen   [2];
  logic [2:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        wt    [2];
  logic        bad   [2];

  always #5 clk = ~clk;

  vscale_dmem_responder #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WT0)) u_dut0 (
    .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
    .dmem_addr(addr[0]), .dmem_wdata_delayed(wdata[0]), .dmem_rdata(rdata[0]),
    .dmem_wait(wt[0]), .dmem_badmem_e(bad[0]));

  vscale_dmem_responder #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WT1)) u_dut1 (
    .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
    .dmem_addr(addr[1]), .dmem_wdata_delayed(wdata[1]), .dmem_rdata(rdata[1]),
    .dmem_wait(wt[1]), .dmem_badmem_e(bad[1]));

  typedef struct {
    bit        v;
    bit        wen;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        bad;
    bit        pin;
    bit [31:0] pin_rdata;
    bit        pin_bad;
  } resp_t;

  resp_t      sched [2][NCYC];
  bit         exw   [2][NCYC];
  logic [7:0] mdl   [2][4*DEPTH];

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  function automatic logic [31:0] base_of(int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int wait_of(int d);
    return (d == 0) ? WT0 : WT1;
  endfunction

  function automatic bit mdl_bad(int d, bit w, bit [2:0] sz, bit [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_of(d));
    if (off < 0 || off >= 4 * DEPTH) return 1'b1;
    case (sz)
      3'd0: return 1'b0;
      3'd1: return a[0];
      3'd2: return (a[1:0] != 2'b00);
      3'd4: return w;
      3'd5: return w | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(int d, bit [2:0] sz, bit [31:0] a);
    int          off;
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(a - base_of(d));
    b = mdl[d][off];
    h = {mdl[d][off+1], mdl[d][off]};
    case (sz)
      3'd0: return 32'(int'($signed(b)));
      3'd1: return 32'(int'($signed(h)));
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return {mdl[d][off+3], mdl[d][off+2], mdl[d][off+1], mdl[d][off]};
    endcase
  endfunction

  function automatic void mdl_store(int d, bit [2:0] sz, bit [31:0] a, bit [31:0] wd);
    int off;
    int n;
    off = int'(a - base_of(d));
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) mdl[d][off+k] = wd[8*k +: 8];
  endfunction

  function automatic void chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", nm, d, cyc, act, exp);
    end
  endfunction

  // Cycle index: value after edge k is k.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Store data is presented by the core in the data phase.
  initial forever begin
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) wdata[d] = sched[d][cyc].v ? sched[d][cyc].wdata : 32'h0;
  end

  // Every cycle: compare both instances against the model, then retire stores.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        resp_t       r;
        logic        eb;
        logic [31:0] er;
        r  = sched[d][cyc];
        eb = 1'b0;
        er = 32'h0;
        if (r.v) begin
          eb = r.bad;
          er = (r.bad || r.wen) ? 32'h0 : mdl_load(d, r.size, r.addr);
        end
        chk("wait", d, {31'h0, wt[d]}, {31'h0, exw[d][cyc]});
        chk("badmem", d, {31'h0, bad[d]}, {31'h0, eb});
        chk("rdata", d, rdata[d], er);
        if (r.v && r.pin) begin
          chk("pin_rdata", d, rdata[d], r.pin_rdata);
          chk("pin_badmem", d, {31'h0, bad[d]}, {31'h0, r.pin_bad});
        end
        if (r.v && !r.bad && r.wen) mdl_store(d, r.size, r.addr, r.wdata);
      end
    end
  end

  // Present one address phase, hold it while the model says the core is
  // stalled, then book the response at capture + WAIT_CYCLES.
  task automatic req(int d, bit w, bit [2:0] sz, bit [31:0] a, bit [31:0] wd,
                     bit pin = 1'b0, bit [31:0] prd = 32'h0, bit pbad = 1'b0);
    int rc;
    en[d] = 1'b1; wen[d] = w; size[d] = sz; addr[d] = a;
    while (exw[d][cyc]) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    for (int k = 0; k < wait_of(d); k++) exw[d][cyc+k] = 1'b1;
    rc = cyc + wait_of(d);
    sched[d][rc] = '{1'b1, w, sz, a, wd, mdl_bad(d, w, sz, a), pin, prd, pbad};
    en[d] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; wen[d] = 1'b0; size[d] = 3'd2; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // No wait states: back-to-back word, byte and halfword traffic.
    req(0, 1, 3'd2, 32'h00, 32'h0000_0000);
    req(0, 1, 3'd2, 32'h20, 32'h1122_3344);
    req(0, 1, 3'd2, 32'h30, 32'h0000_0000);
    req(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    req(0, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0);
    req(0, 1, 3'd0, 32'h21, 32'hABCD_EF80);
    req(0, 0, 3'd0, 32'h21, 32'h0, 1, 32'hFFFF_FF80, 0);
    req(0, 0, 3'd4, 32'h21, 32'h0, 1, 32'h0000_0080, 0);
    req(0, 0, 3'd2, 32'h20, 32'h0, 1, 32'h1122_8044, 0);
    req(0, 1, 3'd1, 32'h32, 32'h5555_8001);
    req(0, 0, 3'd1, 32'h32, 32'h0, 1, 32'hFFFF_8001, 0);
    req(0, 0, 3'd5, 32'h32, 32'h0, 1, 32'h0000_8001, 0);
    req(0, 0, 3'd2, 32'h30, 32'h0, 1, 32'h8001_0000, 0);
    // Error cases: misaligned word, past the top, bad size, misaligned half,
    // unsigned store; word 0 must survive the rejected stores.
    req(0, 0, 3'd2, 32'h02, 32'h0, 1, 32'h0, 1);
    req(0, 1, 3'd2, 32'h100, 32'hFFFF_FFFF, 1, 32'h0, 1);
    req(0, 0, 3'd2, 32'h00, 32'h0, 1, 32'h0, 0);
    req(0, 0, 3'd3, 32'h40, 32'h0, 1, 32'h0, 1);
    req(0, 0, 3'd1, 32'h33, 32'h0, 1, 32'h0, 1);
    req(0, 1, 3'd4, 32'h00, 32'h0000_00FF, 1, 32'h0, 1);
    req(0, 0, 3'd2, 32'h00, 32'h0, 1, 32'h0, 0);
    idle(3);

    // Three wait states, base 0x100; second load is held during the first.
    req(1, 1, 3'd2, 32'h100, 32'h0102_0304);
    req(1, 1, 3'd2, 32'h104, 32'hCAFE_F00D);
    req(1, 0, 3'd2, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 0);
    req(1, 0, 3'd2, 32'h100, 32'h0, 1, 32'h0102_0304, 0);
    req(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h0000_0001, 0);
    req(1, 0, 3'd2, 32'hFC, 32'h0, 1, 32'h0, 1);
    idle(6);

    // Reset in the middle of a store's wait states drops the store.
    req(1, 1, 3'd2, 32'h104, 32'h5555_5555);
    idle(1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = cyc; k < NCYC; k++) begin
        sched[d][k].v = 1'b0;
        exw[d][k] = 1'b0;
      end
    @(negedge clk);
    chk("rst_wait", 1, {31'h0, wt[1]}, 32'h0);
    chk("rst_badmem", 1, {31'h0, bad[1]}, 32'h0);
    chk("rst_rdata", 1, rdata[1], 32'h0);
    @(posedge clk); #1;
    req(1, 0, 3'd2, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 0);
    idle(6);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
